seven_seg_rx: RTL and testbench
===============================

SEVEN_SEG_RX -- requirements
Module: seven_seg_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the number of consecutive identical samples required before a commit; legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 HEX  input  7  SHALL carry the active-low segment pattern, with bit6..bit0 = g..a.
REQ-005 SEL  input  4  SHALL carry the active-low one-hot digit select; SEL[i]=0 selects digit i.
REQ-006 ERR_CLR  input  1  SHALL clear the sticky error flag when high.
REQ-007 D  output  16  SHALL hold the decoded digits, with digit i at D[4i+3:4i].
REQ-008 VALID  output  1  SHALL be a one-cycle pulse marking a digit commit.
REQ-009 IDX  output  2  SHALL give the index of the digit last committed or rejected.
REQ-010 ERR  output  1  SHALL be the sticky flag for an invalid pattern.
REQ-011 ERR_P  output  1  SHALL be a one-cycle pulse marking an invalid-pattern rejection.
REQ-012 ERR_CNT  output  8  SHALL be the error counter (see Configuration).

Function
REQ-013 Decode table SHALL be (hex, HEX value -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-014 The block SHALL register {SEL,HEX} every cycle and compare each new sample against the previous sample.
REQ-015 A legal SEL SHALL have exactly one bit low; any other SEL value SHALL force state IDLE and clear the stability count.
REQ-016 The FSM SHALL have three states: IDLE, TRACK and HOLD.
- IDLE->TRACK on a legal SEL.
- TRACK->HOLD on commit.
- HOLD->TRACK or IDLE on any input change.
REQ-017 A sample differing from the previous one SHALL restart the count at 1; an identical sample SHALL increment the count.
REQ-018 When inputs are stable before edge 1 and held, the commit SHALL occur at edge STABLE_CYCLES, giving a latency of STABLE_CYCLES cycles.
REQ-019 A commit with a pattern found in the table SHALL write that nibble into digit IDX of D, pulse VALID for one cycle, and leave the other digits unchanged.
REQ-020 A commit with HEX=7F (blank) SHALL be silent: no D update, no VALID, no error; IDX SHALL still update.
REQ-021 A commit with any other pattern SHALL leave D unchanged, pulse ERR_P, and set ERR.
REQ-022 In HOLD, the block SHALL NOT re-commit while inputs remain constant, so each stable period yields at most one VALID or ERR_P.
REQ-023 An input change on the edge where a commit would occur SHALL suppress that commit and restart the count at 1.
REQ-024 If ERR_CLR and a new error occur in the same cycle, ERR SHALL end that cycle set (the error wins).
REQ-025 VALID and ERR_P SHALL never be high together.

Reset
REQ-026 Reset SHALL drive D=0000, VALID=0, ERR=0, ERR_P=0, IDX=0, ERR_CNT=0, the count to 0, the sample register to all ones, and the FSM to IDLE.
REQ-027 Reset asserted mid-TRACK SHALL discard the partial count; no commit SHALL occur until STABLE_CYCLES fresh identical samples have been taken after reset deasserts.

Configuration
REQ-028 With macro SEVEN_SEG_RX_ERR_COUNT_EN defined:
- ERR_CNT SHALL increment on each ERR_P pulse.
- ERR_CNT SHALL saturate at FF.
- ERR_CNT SHALL clear on reset or ERR_CLR.
- On a simultaneous ERR_CLR and error, ERR_CNT SHALL take the value 01.
REQ-029 Without SEVEN_SEG_RX_ERR_COUNT_EN, ERR_CNT SHALL be tied to 00, no counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-030 SEL=1110, HEX=19 held for 6 cycles (STABLE_CYCLES=4) -> VALID for exactly one cycle at edge 4, D=0004, IDX=0.
REQ-031 SEL=0111, HEX=0E for 3 cycles, then HEX=06 for 4 cycles -> no commit for 0E; D[15:12]=E; VALID once.
REQ-032 SEL=1101, HEX=55 held for 5 cycles -> ERR_P once, ERR=1, D unchanged; with the macro defined, ERR_CNT=01.
REQ-033 SEL=1100, HEX=40 for 10 cycles -> no VALID, no ERR_P; SEL=1111 likewise.
REQ-034 Reset pulsed at cycle 2 of a stable SEL=1011, HEX=24 -> VALID occurs 4 cycles after reset deasserts, D=0200.
REQ-035 ERR=1, then ERR_CLR asserted together with a new invalid commit -> ERR remains 1; with the macro defined, ERR_CNT=01.

Source files
------------

// File: rtl/seven_seg_rx.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_rx
// Brief    : Seven-segment display receiver. Debounces the multiplexed
//            {SEL,HEX} bus and decodes each stable digit into a nibble of D.
//            Optional macro SEVEN_SEG_RX_ERR_COUNT_EN enables a saturating
//            error counter on ERR_CNT.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  HEX,
  input  logic [3:0]  SEL,
  input  logic        ERR_CLR,
  output logic [15:0] D,
  output logic        VALID,
  output logic [1:0]  IDX,
  output logic        ERR,
  output logic        ERR_P,
  output logic [7:0]  ERR_CNT
);

  localparam logic [7:0] c_STABLE    = 8'(STABLE_CYCLES);
  localparam logic [7:0] c_STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] c_BLANK     = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [10:0] w_samp, r_prev;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        w_same, w_legal, w_commit;
  logic [1:0]  w_idx;
  logic        w_found;
  logic [3:0]  w_nib;
  logic        w_blank, w_commit_ok, w_commit_err;
  logic [15:0] r_d;
  logic        r_valid, r_err, r_err_p;
  logic [1:0]  r_idx;

  assign w_samp = {SEL, HEX};
  assign w_same = (w_samp == r_prev);

  always_comb begin
    w_legal = 1'b1;
    w_idx   = 2'd0;
    case (SEL)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_found = 1'b1;
    w_nib   = 4'h0;
    case (HEX)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_found = 1'b0;
    endcase
  end

  // The count includes the current sample, so a commit fires on the edge
  // where the STABLE_CYCLES-th identical sample arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (!w_legal) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = w_same ? r_cnt + 8'd1 : 8'd1;
        end
        ST_TRACK: begin
          if (!w_same) begin
            w_cnt_nxt = 8'd1;
          end else if (r_cnt == c_STABLE_M1) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = c_STABLE;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (!w_same) begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = 8'd1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  assign w_blank      = (HEX == c_BLANK);
  assign w_commit_ok  = w_commit & w_found;
  assign w_commit_err = w_commit & ~w_found & ~w_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_prev  <= '1;
      r_d     <= 16'h0000;
      r_valid <= 1'b0;
      r_err_p <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= w_samp;
      r_valid <= w_commit_ok;
      r_err_p <= w_commit_err;
      if (w_commit) r_idx <= w_idx;
      if (w_commit_ok) r_d[{w_idx, 2'b00} +: 4] <= w_nib;
      // A new error outranks a simultaneous clear request.
      if (w_commit_err) r_err <= 1'b1;
      else if (ERR_CLR) r_err <= 1'b0;
    end
  end

  assign D     = r_d;
  assign VALID = r_valid;
  assign ERR_P = r_err_p;
  assign ERR   = r_err;
  assign IDX   = r_idx;

`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= 8'h00;
    end else if (w_commit_err) begin
      if (ERR_CLR) r_err_cnt <= 8'h01;
      else if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
    end else if (ERR_CLR) begin
      r_err_cnt <= 8'h00;
    end
  end

  assign ERR_CNT = r_err_cnt;
`else
  assign ERR_CNT = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_rx
// Brief    : Directed self-checking bench for seven_seg_rx (STABLE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  HEX;
  logic [3:0]  SEL;
  logic        ERR_CLR;
  logic [15:0] D;
  logic        VALID;
  logic [1:0]  IDX;
  logic        ERR;
  logic        ERR_P;
  logic [7:0]  ERR_CNT;

  int vectors    = 0;
  int miscompares = 0;

`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
  localparam logic [7:0] c_CNT1 = 8'h01;
  localparam logic [7:0] c_CNT2 = 8'h02;
`else
  localparam logic [7:0] c_CNT1 = 8'h00;
  localparam logic [7:0] c_CNT2 = 8'h00;
`endif

  seven_seg_rx #(.STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .HEX     (HEX),
    .SEL     (SEL),
    .ERR_CLR (ERR_CLR),
    .D       (D),
    .VALID   (VALID),
    .IDX     (IDX),
    .ERR     (ERR),
    .ERR_P   (ERR_P),
    .ERR_CNT (ERR_CNT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n edges; VALID/ERR_P must pulse only after edge v_at / e_at (0 = never).
  task automatic watch(input string tag, input int n, input int v_at, input int e_at);
    for (int i = 1; i <= n; i++) begin
      tick();
      check({tag, ".valid"}, 16'(VALID), 16'(i == v_at));
      check({tag, ".errp"},  16'(ERR_P), 16'(i == e_at));
    end
  endtask

  logic [6:0]  tbl [16];
  logic [15:0] exp_d;

  initial begin
    tbl[0]  = 7'h40; tbl[1]  = 7'h79; tbl[2]  = 7'h24; tbl[3]  = 7'h30;
    tbl[4]  = 7'h19; tbl[5]  = 7'h12; tbl[6]  = 7'h02; tbl[7]  = 7'h78;
    tbl[8]  = 7'h00; tbl[9]  = 7'h10; tbl[10] = 7'h08; tbl[11] = 7'h03;
    tbl[12] = 7'h46; tbl[13] = 7'h21; tbl[14] = 7'h06; tbl[15] = 7'h0E;

    reset = 1'b1; SEL = 4'hF; HEX = 7'h7F; ERR_CLR = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst.d", D, 16'h0000);
    check("rst.valid", 16'(VALID), 16'd0);
    check("rst.errp", 16'(ERR_P), 16'd0);
    check("rst.err", 16'(ERR), 16'd0);
    check("rst.idx", 16'(IDX), 16'd0);
    check("rst.cnt", 16'(ERR_CNT), 16'd0);

    // Digit 0 = 4, commit on the fourth edge only
    SEL = 4'b1110; HEX = 7'h19;
    watch("d0_4", 6, 4, 0);
    check("d0_4.d", D, 16'h0004);
    check("d0_4.idx", 16'(IDX), 16'd0);

    // Short burst of F never commits; E then commits on digit 3
    SEL = 4'b0111; HEX = 7'h0E;
    watch("d3_short", 3, 0, 0);
    HEX = 7'h06;
    watch("d3_e", 4, 4, 0);
    check("d3_e.d", D, 16'hE004);
    check("d3_e.idx", 16'(IDX), 16'd3);

    // Invalid pattern on digit 1
    SEL = 4'b1101; HEX = 7'h55;
    watch("bad", 5, 0, 4);
    check("bad.err", 16'(ERR), 16'd1);
    check("bad.d", D, 16'hE004);
    check("bad.idx", 16'(IDX), 16'd1);
    check("bad.cnt", 16'(ERR_CNT), 16'(c_CNT1));

    // Illegal selects never commit
    SEL = 4'b1100; HEX = 7'h40;
    watch("sel2low", 10, 0, 0);
    SEL = 4'b1111;
    watch("selnone", 10, 0, 0);
    check("sel.d", D, 16'hE004);
    check("sel.idx", 16'(IDX), 16'd1);

    // Blank commit: silent apart from IDX
    SEL = 4'b1110; HEX = 7'h7F;
    watch("blank", 6, 0, 0);
    check("blank.idx", 16'(IDX), 16'd0);
    check("blank.d", D, 16'hE004);
    check("blank.err", 16'(ERR), 16'd1);

    // Full decode table, rotating through digits
    exp_d = 16'hE004;
    for (int n = 0; n < 16; n++) begin
      SEL = ~(4'b0001 << (n % 4));
      HEX = tbl[n];
      watch("table", 4, 4, 0);
      exp_d[4*(n%4) +: 4] = 4'(n);
      check("table.d", D, exp_d);
      check("table.idx", 16'(IDX), 16'(n % 4));
    end
    check("table.final", D, 16'hFEDC);

    // Reset mid-track discards partial count
    SEL = 4'b1011; HEX = 7'h24;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst.d", D, 16'h0000);
    check("midrst.err", 16'(ERR), 16'd0);
    check("midrst.idx", 16'(IDX), 16'd0);
    reset = 1'b0;
    watch("midrst", 5, 4, 0);
    check("midrst.d2", D, 16'h0200);
    check("midrst.idx2", 16'(IDX), 16'd2);

    // Change on the would-be commit edge restarts the count
    SEL = 4'b0111; HEX = 7'h40;
    watch("restart_a", 3, 0, 0);
    HEX = 7'h79;
    watch("restart_b", 5, 4, 0);
    check("restart.d", D, 16'h1200);
    check("restart.idx", 16'(IDX), 16'd3);

    // Two errors, then clear coinciding with a third error
    SEL = 4'b1110; HEX = 7'h55;
    watch("e1", 4, 0, 4);
    HEX = 7'h56;
    watch("e2", 4, 0, 4);
    check("e2.err", 16'(ERR), 16'd1);
    check("e2.cnt", 16'(ERR_CNT), 16'(c_CNT2));
    SEL = 4'b1101; HEX = 7'h55;
    watch("e3", 3, 0, 0);
    ERR_CLR = 1'b1;
    tick();
    check("clrerr.errp", 16'(ERR_P), 16'd1);
    check("clrerr.valid", 16'(VALID), 16'd0);
    check("clrerr.err", 16'(ERR), 16'd1);
    check("clrerr.cnt", 16'(ERR_CNT), 16'(c_CNT1));
    tick();
    check("clr.errp", 16'(ERR_P), 16'd0);
    check("clr.err", 16'(ERR), 16'd0);
    check("clr.cnt", 16'(ERR_CNT), 16'd0);
    ERR_CLR = 1'b0;
    check("clr.d", D, 16'h1200);

`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
    // Counter saturation
    SEL = 4'b1110;
    for (int k = 0; k < 260; k++) begin
      HEX = (k % 2 == 0) ? 7'h55 : 7'h56;
      tick(); tick(); tick(); tick();
    end
    check("sat.cnt", 16'(ERR_CNT), 16'h00FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
